dmi_responder: RTL



---
 rtl/dmi_responder.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/dmi_responder.sv
// dmi_responder
//   DMI target endpoint. Requests arrive on a valid/ready channel and are
//   applied to a bank of 32-bit registers mapped at BASE_ADDR ..
//   BASE_ADDR+NUM_REGS-1. Each request gets exactly one response on a
//   valid/ready response channel. A hart-side write port updates the same
//   registers, giving a debugger/software mailbox.
//
// Parameters
//   BASE_ADDR   first DMI address of the register window
//   NUM_REGS    number of registers (1..32)
//   RD_LATENCY  extra wait cycles before read data is sampled (0..7)
//
// Ports
//   CLK, RST_N        clock, asynchronous active-low reset
//   dmi_req_valid     request valid
//   dmi_req_ready     request ready (high only while idle)
//   dmi_req_addr      7-bit request address
//   dmi_req_data      write data
//   dmi_req_op        0 nop, 1 read, 2 write, 3 reserved
//   dmi_rsp_valid     response valid
//   dmi_rsp_ready     response ready
//   dmi_rsp_data      read data (0 for non-read or failed requests)
//   dmi_rsp_response  0 success, 2 failed
//   hart_wr_en        hart-side write strobe
//   hart_wr_idx       hart-side register index
//   hart_wr_data      hart-side write data
//   err_count         saturating count of failed responses
module dmi_responder #(
    parameter logic [6:0] BASE_ADDR  = 7'h04,
    parameter int         NUM_REGS   = 8,
    parameter int         RD_LATENCY = 1
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        dmi_req_valid,
    output logic        dmi_req_ready,
    input  logic [6:0]  dmi_req_addr,
    input  logic [31:0] dmi_req_data,
    input  logic [1:0]  dmi_req_op,
    output logic        dmi_rsp_valid,
    input  logic        dmi_rsp_ready,
    output logic [31:0] dmi_rsp_data,
    output logic [1:0]  dmi_rsp_response,
    input  logic        hart_wr_en,
    input  logic [4:0]  hart_wr_idx,
    input  logic [31:0] hart_wr_data,
    output logic [7:0]  err_count
);

    localparam int         IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [6:0] NUM_REGS_A = 7'(NUM_REGS);
    localparam logic [5:0] NUM_REGS_H = 6'(NUM_REGS);
    localparam logic [2:0] LAT_LOAD   = 3'((RD_LATENCY > 0) ? RD_LATENCY - 1 : 0);

    localparam logic [1:0] OP_RD    = 2'd1;
    localparam logic [1:0] OP_WR    = 2'd2;
    localparam logic [1:0] OP_RSV   = 2'd3;
    localparam logic [1:0] RSP_OK   = 2'd0;
    localparam logic [1:0] RSP_FAIL = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    state_t             state;
    logic [2:0]         lat_cnt;
    logic [IDX_W-1:0]   rd_idx;
    logic [31:0]        regs [NUM_REGS];

    logic [6:0]         req_off;
    logic               req_hit;
    logic [IDX_W-1:0]   req_idx;
    logic               req_fail;
    logic               hart_hit;
    logic [IDX_W-1:0]   hart_idx;
    logic               accept;

    // The offset is a 7-bit wrap-around subtraction: addresses below the
    // window wrap to large values and fall out of range naturally.
    assign req_off  = dmi_req_addr - BASE_ADDR;
    assign req_hit  = req_off < NUM_REGS_A;
    assign req_idx  = req_off[IDX_W-1:0];
    assign req_fail = (dmi_req_op == OP_RSV) ||
                      (((dmi_req_op == OP_RD) || (dmi_req_op == OP_WR)) && !req_hit);
    assign hart_hit = hart_wr_en && ({1'b0, hart_wr_idx} < NUM_REGS_H);
    assign hart_idx = hart_wr_idx[IDX_W-1:0];
    assign accept   = dmi_req_valid && dmi_req_ready;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state            <= IDLE;
            dmi_req_ready    <= 1'b0;
            dmi_rsp_valid    <= 1'b0;
            dmi_rsp_data     <= '0;
            dmi_rsp_response <= RSP_OK;
            err_count        <= '0;
            lat_cnt          <= '0;
            rd_idx           <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            // Hart write goes first so a same-edge DMI write to the same
            // register below overrides it.
            if (hart_hit) begin
                regs[hart_idx] <= hart_wr_data;
            end

            case (state)
                IDLE: begin
                    // ready rises on the first edge after reset release and
                    // drops on the accept edge.
                    dmi_req_ready <= 1'b1;
                    if (accept) begin
                        dmi_req_ready <= 1'b0;
                        if (req_fail) begin
                            err_count        <= sat_inc8(err_count);
                            dmi_rsp_data     <= '0;
                            dmi_rsp_response <= RSP_FAIL;
                            dmi_rsp_valid    <= 1'b1;
                            state            <= RESP;
                        end else if (dmi_req_op == OP_RD) begin
                            if (RD_LATENCY == 0) begin
                                dmi_rsp_data     <= regs[req_idx];
                                dmi_rsp_response <= RSP_OK;
                                dmi_rsp_valid    <= 1'b1;
                                state            <= RESP;
                            end else begin
                                lat_cnt <= LAT_LOAD;
                                rd_idx  <= req_idx;
                                state   <= WAIT;
                            end
                        end else begin
                            if (dmi_req_op == OP_WR) begin
                                regs[req_idx] <= dmi_req_data;
                            end
                            dmi_rsp_data     <= '0;
                            dmi_rsp_response <= RSP_OK;
                            dmi_rsp_valid    <= 1'b1;
                            state            <= RESP;
                        end
                    end
                end

                WAIT: begin
                    if (lat_cnt == 3'd0) begin
                        // Non-blocking read: a hart write on this same edge
                        // is not yet visible, so the old value is returned.
                        dmi_rsp_data     <= regs[rd_idx];
                        dmi_rsp_response <= RSP_OK;
                        dmi_rsp_valid    <= 1'b1;
                        state            <= RESP;
                    end else begin
                        lat_cnt <= lat_cnt - 3'd1;
                    end
                end

                RESP: begin
                    if (dmi_rsp_ready) begin
                        dmi_rsp_valid <= 1'b0;
                        dmi_req_ready <= 1'b1;
                        state         <= IDLE;
                    end
                end

                default: begin
                    dmi_rsp_valid <= 1'b0;
                    dmi_req_ready <= 1'b0;
                    state         <= IDLE;
                end
            endcase
        end
    end

endmodule
